mmio_port_responder: RTL and testbench



---
 rtl/mmio_pkg.sv | 16 +
 rtl/mmio_port_responder_sync.sv | 23 ++
 rtl/mmio_port_responder.sv | 118 +++++++++++
 tb/tb_mmio_port_responder.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/mmio_pkg.sv
// mmio_pkg: register offsets, STATUS/CTRL bit indices and handshake states shared by mmio_port_responder.
package mmio_pkg;
    localparam logic [3:0] OFS_OUT    = 4'h0;
    localparam logic [3:0] OFS_IN     = 4'h4;
    localparam logic [3:0] OFS_STATUS = 4'h8;
    localparam logic [3:0] OFS_CTRL   = 4'hC;

    localparam int ST_CHANGED = 0;
    localparam int ST_BUSY    = 1;
    localparam int ST_OVERRUN = 2;

    localparam int CTRL_CLR_CHANGED = 0;
    localparam int CTRL_CLR_OVERRUN = 1;

    typedef enum logic [1:0] {IDLE, SEND, WAIT_LOW} state_e;
endpackage

// File: rtl/mmio_port_responder_sync.sv
// sync_2ff: two-flop synchronizer for asynchronous inputs, synchronous active-low reset.
module sync_2ff #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);
    logic [W-1:0] s1_q, s2_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= d_i;
            s2_q <= s1_q;
        end
    end

    assign q_o = s2_q;
endmodule

// File: rtl/mmio_port_responder.sv
// mmio_port_responder: 4-register MMIO window with a valid/ack PortOut handshake and a synchronized PortIn sampler.
// Define PORTIN_DEBOUNCE_EN to require DEBOUNCE_CYCLES stable cycles before PortIn is accepted.
module mmio_port_responder
    import mmio_pkg::*;
#(
    parameter logic [31:0] BASE_ADDRESS    = 32'h1001_0040,
    parameter int          DEBOUNCE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    input  logic        MemWrite,
    input  logic        MemRead,
    output logic [31:0] ReadData,
    output logic        Hit,
    input  logic [7:0]  PortIn,
    output logic [31:0] PortOut,
    output logic        PortOutValid,
    input  logic        PortOutAck
);
    logic [7:0]  pin_s, in_reg_q, in_reg_d;
    logic        ack_s, in_changed_q, overrun_q, valid_q, busy;
    logic        wr_out, wr_ctrl;
    logic [3:0]  ofs;
    logic [31:0] port_out_q, status;
    state_e      state_q;

    sync_2ff #(.W(8)) u_sync_pin (.clk(clk), .reset(reset), .d_i(PortIn), .q_o(pin_s));
    sync_2ff #(.W(1)) u_sync_ack (.clk(clk), .reset(reset), .d_i(PortOutAck), .q_o(ack_s));

    // Byte lane bits are masked off so any address within a word selects it.
    assign ofs     = Address[3:0] & 4'b1100;
    assign Hit     = Address[31:4] == BASE_ADDRESS[31:4];
    assign wr_out  = MemWrite && Hit && ofs == OFS_OUT;
    assign wr_ctrl = MemWrite && Hit && ofs == OFS_CTRL;
    assign busy    = state_q != IDLE;

`ifdef PORTIN_DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    logic [CW-1:0] cnt_q;
    logic [7:0]    prev_q;
    logic          stable_done;

    // prev_q holds last cycle's sync output, so any change in the candidate restarts the count.
    assign stable_done = pin_s != in_reg_q && pin_s == prev_q && cnt_q == CW'(DEBOUNCE_CYCLES);
    assign in_reg_d    = stable_done ? pin_s : in_reg_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q  <= '0;
            prev_q <= '0;
        end else begin
            prev_q <= pin_s;
            if (pin_s == in_reg_q || stable_done)
                cnt_q <= '0;
            else if (pin_s != prev_q)
                cnt_q <= CW'(1);
            else if (cnt_q != CW'(DEBOUNCE_CYCLES))
                cnt_q <= cnt_q + CW'(1);
        end
    end
`else
    assign in_reg_d = pin_s;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            in_reg_q     <= '0;
            in_changed_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            in_reg_q     <= in_reg_d;
            in_changed_q <= in_reg_d != in_reg_q || (in_changed_q && !(wr_ctrl && WriteData[CTRL_CLR_CHANGED]));
            overrun_q    <= (wr_out && busy) || (overrun_q && !(wr_ctrl && WriteData[CTRL_CLR_OVERRUN]));
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            port_out_q <= '0;
            valid_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (wr_out) begin
                    port_out_q <= WriteData;
                    valid_q    <= 1'b1;
                    state_q    <= SEND;
                end
                SEND: if (ack_s) begin
                    valid_q <= 1'b0;
                    state_q <= WAIT_LOW;
                end
                WAIT_LOW: if (!ack_s) state_q <= IDLE;
                default: begin
                    valid_q <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        status             = '0;
        status[ST_CHANGED] = in_changed_q;
        status[ST_BUSY]    = busy;
        status[ST_OVERRUN] = overrun_q;
    end

    assign ReadData = !(Hit && MemRead) ? '0 :
                      ofs == OFS_OUT    ? port_out_q :
                      ofs == OFS_IN     ? {24'b0, in_reg_q} :
                      ofs == OFS_STATUS ? status : '0;

    assign PortOut      = port_out_q;
    assign PortOutValid = valid_q;
endmodule

// File: tb/tb_mmio_port_responder.sv
// tb_mmio_port_responder: table-driven bus vectors plus directed handshake, input-latency and reset sequences.
module tb_mmio_port_responder;
`ifdef PORTIN_DEBOUNCE_EN
    localparam int LAT = 7;
`else
    localparam int LAT = 3;
`endif
    localparam logic [31:0] A_OUT = 32'h1001_0040, A_IN = 32'h1001_0044;
    localparam logic [31:0] A_ST = 32'h1001_0048, A_CTRL = 32'h1001_004C;

    logic clk = 0, reset = 0, MemWrite = 0, MemRead = 0, Hit, PortOutValid, PortOutAck = 0;
    logic [31:0] Address = 0, WriteData = 0, ReadData, PortOut;
    logic [7:0] PortIn = 0;
    int tests = 0, fails = 0;

    mmio_port_responder dut (
        .clk(clk), .reset(reset), .Address(Address), .WriteData(WriteData),
        .MemWrite(MemWrite), .MemRead(MemRead), .ReadData(ReadData), .Hit(Hit),
        .PortIn(PortIn), .PortOut(PortOut), .PortOutValid(PortOutValid), .PortOutAck(PortOutAck)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we, re;
        logic [31:0] addr, wdata;
        logic [7:0]  pin;
        int          wait_cyc;
        logic        exp_hit;
        logic [31:0] exp_rd, exp_pout;
        logic        exp_valid;
    } vec_t;
    vec_t v[21];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic peek(input string nm, input logic [31:0] a, input logic [31:0] exp);
        Address = a;
        MemRead = 1;
        #1 check(nm, ReadData, exp);
        MemRead = 0;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        Address = a; WriteData = d; MemWrite = 1;
        @(posedge clk);
        #1 MemWrite = 0;
    endtask

    task automatic apply(input vec_t t, input int i);
        @(negedge clk);
        PortIn = t.pin; MemWrite = 0; MemRead = 0;
        repeat (t.wait_cyc) @(negedge clk);
        Address = t.addr; WriteData = t.wdata; MemWrite = t.we; MemRead = t.re;
        #1;
        check($sformatf("v%0d hit", i), {31'b0, Hit}, {31'b0, t.exp_hit});
        check($sformatf("v%0d rdata", i), ReadData, t.exp_rd);
        @(posedge clk);
        #1 MemWrite = 0; MemRead = 0;
        check($sformatf("v%0d portout", i), PortOut, t.exp_pout);
        check($sformatf("v%0d valid", i), {31'b0, PortOutValid}, {31'b0, t.exp_valid});
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        v[0]  = '{0, 1, A_ST,           0,            8'h00, 0,     1, 32'h0,         32'h0,         0};
        v[1]  = '{0, 1, A_OUT,          0,            8'h00, 0,     1, 32'h0,         32'h0,         0};
        v[2]  = '{0, 1, 32'h1001_0000,  0,            8'h00, 0,     0, 32'h0,         32'h0,         0};
        v[3]  = '{1, 0, 32'h1001_0000,  32'hDEAD_BEEF,8'h00, 0,     0, 32'h0,         32'h0,         0};
        v[4]  = '{1, 0, A_IN,           32'h1111,     8'h00, 0,     1, 32'h0,         32'h0,         0};
        v[5]  = '{0, 1, A_CTRL,         0,            8'h00, 0,     1, 32'h0,         32'h0,         0};
        v[6]  = '{0, 1, 32'h1001_0050,  0,            8'h00, 0,     0, 32'h0,         32'h0,         0};
        v[7]  = '{0, 1, 32'h1001_003C,  0,            8'h00, 0,     0, 32'h0,         32'h0,         0};
        v[8]  = '{0, 1, A_IN,           0,            8'hA5, LAT+1, 1, 32'hA5,        32'h0,         0};
        v[9]  = '{0, 1, A_ST,           0,            8'hA5, 0,     1, 32'h1,         32'h0,         0};
        v[10] = '{1, 0, A_CTRL,         32'h1,        8'hA5, 0,     1, 32'h0,         32'h0,         0};
        v[11] = '{0, 1, A_ST,           0,            8'hA5, 0,     1, 32'h0,         32'h0,         0};
        v[12] = '{1, 1, A_OUT,          32'hCAFE_0001,8'hA5, 0,     1, 32'h0,         32'hCAFE_0001, 1};
        v[13] = '{0, 1, A_ST,           0,            8'hA5, 0,     1, 32'h2,         32'hCAFE_0001, 1};
        v[14] = '{1, 0, A_OUT,          32'h1234,     8'hA5, 0,     1, 32'h0,         32'hCAFE_0001, 1};
        v[15] = '{0, 1, A_ST,           0,            8'hA5, 0,     1, 32'h6,         32'hCAFE_0001, 1};
        v[16] = '{1, 0, A_CTRL,         32'h2,        8'hA5, 0,     1, 32'h0,         32'hCAFE_0001, 1};
        v[17] = '{0, 1, A_ST,           0,            8'hA5, 0,     1, 32'h2,         32'hCAFE_0001, 1};
        v[18] = '{0, 1, A_OUT,          0,            8'hA5, 0,     1, 32'hCAFE_0001, 32'hCAFE_0001, 1};
        v[19] = '{0, 1, 32'h1001_0043,  0,            8'hA5, 0,     1, 32'hCAFE_0001, 32'hCAFE_0001, 1};
        v[20] = '{0, 1, 32'h1001_0046,  0,            8'hA5, 0,     1, 32'hA5,        32'hCAFE_0001, 1};

        repeat (2) @(posedge clk);
        #1;
        check("rst portout", PortOut, 32'h0);
        check("rst valid", {31'b0, PortOutValid}, 32'h0);
        @(negedge clk) reset = 1;

        foreach (v[i]) apply(v[i], i);

        // ack handshake: valid drops once the synchronized ack is seen
        @(negedge clk) PortOutAck = 1;
        @(posedge clk) #1 check("ack valid held", {31'b0, PortOutValid}, 32'h1);
        repeat (2) @(posedge clk);
        #1 check("ack valid dropped", {31'b0, PortOutValid}, 32'h0);
        @(negedge clk) peek("wait_low busy", A_ST, 32'h2);
        PortOutAck = 0;
        @(negedge clk) peek("ack low busy", A_ST, 32'h2);
        repeat (2) @(negedge clk);
        peek("back idle", A_ST, 32'h0);

        // CTRL clear on the same edge in_reg changes: set wins
        @(negedge clk) PortIn = 8'h5A;
        repeat (LAT - 1) @(negedge clk);
        peek("in before lat", A_IN, 32'hA5);
        Address = A_CTRL; WriteData = 32'h1; MemWrite = 1;
        @(posedge clk) #1 MemWrite = 0;
        @(negedge clk);
        peek("set beats clear", A_ST, 32'h1);
        peek("in 5a", A_IN, 32'h5A);
        store(A_CTRL, 32'h1);
        @(negedge clk) peek("changed cleared", A_ST, 32'h0);

        // reset mid-handshake
        store(A_OUT, 32'h77);
        check("out 77", PortOut, 32'h77);
        check("valid 77", {31'b0, PortOutValid}, 32'h1);
        @(negedge clk) begin reset = 0; PortIn = 8'h00; end
        @(posedge clk) #1;
        check("midrst valid", {31'b0, PortOutValid}, 32'h0);
        check("midrst portout", PortOut, 32'h0);
        @(negedge clk) reset = 1;
        peek("midrst status", A_ST, 32'h0);

`ifdef PORTIN_DEBOUNCE_EN
        @(negedge clk) PortIn = 8'hFF;
        repeat (3) @(negedge clk);
        PortIn = 8'h00;
        repeat (10) @(negedge clk);
        peek("glitch in", A_IN, 32'h0);
        peek("glitch status", A_ST, 32'h0);
`endif
        // exact input latency
        @(negedge clk) PortIn = 8'h3C;
        repeat (LAT - 1) @(negedge clk);
        peek("3c early", A_IN, 32'h0);
        @(negedge clk) peek("3c on time", A_IN, 32'h3C);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
